// File: rtl/pe_cfg_pkg.sv
// Shared definitions for the PE configuration loader.
//   CFG_W      : width of one PE_Configure_Inport beat ({valid, word})
//   CFG_DATA_W : width of the configuration word carried by a beat
//   state_t    : loader sequencing states
package pe_cfg_pkg;

  localparam int CFG_W      = 33;
  localparam int CFG_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_GAP
  } state_t;

endpackage

// File: rtl/pe_cfg_fifo.sv
// Synchronous FIFO buffering configuration entries {last, pe, data}.
//   clk, reset : clock, asynchronous active-low reset (pointers only)
//   flush      : empties the FIFO on the next edge, overriding push/pop
//   push/wr_data, pop/rd_data : write port, show-ahead read port
//   full/empty : status derived from the registered pointers
module pe_cfg_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra wrap bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pe_cfg_loader.sv
// Transmit end of the PE configuration interface. Buffers configuration
// words from a host/DMA stream and replays them, one beat per cycle, onto
// the PE_Configure_Inport of the selected PE.
//   clk, reset           : clock, asynchronous active-low reset
//   s_valid/s_ready      : input handshake (s_ready = FIFO not full)
//   s_data/s_pe/s_last   : configuration word, target PE, end of packet
//   start / abort        : begin streaming from IDLE / flush and go IDLE
//   cfg_bus              : slice k = [k*33 +: 33] drives PE k
//   busy, pkt_done, pkt_cnt, underrun, bad_id : status
module pe_cfg_loader
  import pe_cfg_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int PE_ID_W    = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [CFG_DATA_W-1:0]   s_data,
  input  logic [PE_ID_W-1:0]      s_pe,
  input  logic                    s_last,
  input  logic                    start,
  input  logic                    abort,
  output logic [NUM_PE*CFG_W-1:0] cfg_bus,
  output logic                    busy,
  output logic                    pkt_done,
  output logic [15:0]             pkt_cnt,
  output logic                    underrun,
  output logic                    bad_id
);

  localparam int ENTRY_W = CFG_DATA_W + PE_ID_W + 1;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t                state;
  state_t                state_nxt;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  gap_done;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_rd;
  logic                  mid_pkt;

  logic                  vld_p0;
  logic [CFG_DATA_W-1:0] data_p0;
  logic [PE_ID_W-1:0]    pe_p0;
  logic                  last_p0;
  logic                  id_ok_p0;

  logic                  vld_p1;
  logic                  last_p1;
  logic [CFG_DATA_W-1:0] data_p1;
  logic [PE_ID_W-1:0]    pe_p1;

  assign s_ready = !fifo_full;

  pe_cfg_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (abort),
    .push    (s_valid && s_ready),
    .wr_data ({s_last, s_pe, s_data}),
    .pop     (vld_p0),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ---- stage p0: FIFO head, pop decision ----
  assign last_p0  = fifo_rd[ENTRY_W-1];
  assign pe_p0    = fifo_rd[CFG_DATA_W +: PE_ID_W];
  assign data_p0  = fifo_rd[CFG_DATA_W-1:0];
  assign vld_p0   = (state == ST_STREAM) && !fifo_empty && !abort;
  assign id_ok_p0 = (32'(pe_p0) < NUM_PE);
  assign gap_done = (int'(gap_cnt) >= GAP_CYCLES - 1);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_STREAM;
      ST_STREAM: if (vld_p0 && last_p0 && (GAP_CYCLES > 0)) state_nxt = ST_GAP;
      ST_GAP:    if (gap_done) state_nxt = ST_STREAM;
      default:   state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  // ---- stage p1: registered beat and status ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      mid_pkt  <= 1'b0;
      pkt_cnt  <= '0;
      underrun <= 1'b0;
      bad_id   <= 1'b0;
    end else begin
      // A discarded bad-id word still closes its packet.
      vld_p1  <= vld_p0 && id_ok_p0;
      last_p1 <= vld_p0 && last_p0;
      if (vld_p0 && last_p0)   pkt_cnt <= pkt_cnt + 16'd1;
      if (vld_p0 && !id_ok_p0) bad_id  <= 1'b1;
      if (abort)       mid_pkt <= 1'b0;
      else if (vld_p0) mid_pkt <= !last_p0;
      if ((state == ST_STREAM) && fifo_empty && mid_pkt && !abort) underrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      data_p1 <= data_p0;
      pe_p1   <= pe_p0;
    end
  end

  // Only the slice addressed by the registered beat is driven.
  always_comb begin
    cfg_bus = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (vld_p1 && (pe_p1 == PE_ID_W'(k))) cfg_bus[k*CFG_W +: CFG_W] = {1'b1, data_p1};
    end
  end

  assign busy     = (state != ST_IDLE);
  assign pkt_done = last_p1;

endmodule

// File: tb/tb_pe_cfg_loader.sv
module tb_pe_cfg_loader;

  localparam int NUM_PE  = 3;
  localparam int PE_ID_W = 2;
  localparam int DEPTH   = 16;
  localparam int GAP     = 1;
  localparam int BUS_W   = NUM_PE * 33;

  logic               clk;
  logic               reset;
  logic               s_valid;
  logic               s_ready;
  logic [31:0]        s_data;
  logic [PE_ID_W-1:0] s_pe;
  logic               s_last;
  logic               start;
  logic               abort;
  logic [BUS_W-1:0]   cfg_bus;
  logic               busy;
  logic               pkt_done;
  logic [15:0]        pkt_cnt;
  logic               underrun;
  logic               bad_id;

  pe_cfg_loader #(
    .NUM_PE     (NUM_PE),
    .PE_ID_W    (PE_ID_W),
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_pe     (s_pe),
    .s_last   (s_last),
    .start    (start),
    .abort    (abort),
    .cfg_bus  (cfg_bus),
    .busy     (busy),
    .pkt_done (pkt_done),
    .pkt_cnt  (pkt_cnt),
    .underrun (underrun),
    .bad_id   (bad_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BUS_W-1:0] bus;
    logic             done;
  } exp_t;

  typedef struct {
    logic             v;
    logic [1:0]       pe;
    logic [31:0]      d;
    logic             l;
    logic [BUS_W-1:0] exp_bus;
    logic             exp_done;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          mon_nz;
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_cnt = 0;
  logic        mon_en = 1'b0;
  vec_t        t1[6];
  logic [BUS_W-1:0] exp2_bus[6];
  logic        exp2_done[6];

  function automatic logic [BUS_W-1:0] slice_val(int pe, logic [31:0] d);
    logic [BUS_W-1:0] v;
    v = '0;
    v[pe*33 +: 33] = {1'b1, d};
    return v;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_expect(int pe, logic [31:0] d, logic l);
    exp_t e;
    if (l) exp_cnt++;
    if (pe < NUM_PE) begin
      e.bus  = slice_val(pe, d);
      e.done = l;
      sb.push_back(e);
    end
  endtask

  task automatic push_word(int pe, logic [31:0] d, logic l);
    logic ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_pe    = PE_ID_W'(pe);
    s_data  = d;
    s_last  = l;
    for (int g = 0; g < 64 && !ok; g++) begin
      ok = s_ready;
      tick();
    end
    s_valid = 1'b0;
    check("push_accepted", ok, 1'b1);
    if (ok) sb_expect(pe, d, l);
  endtask

  task automatic drain(int budget);
    for (int g = 0; g < budget && sb.size() != 0; g++) tick();
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb.delete();
  endtask

  // Scoreboard: every beat on cfg_bus must match the oldest expected word.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_nz = 0;
      for (int k = 0; k < NUM_PE; k++)
        if (cfg_bus[k*33 +: 33] != 33'd0) mon_nz++;
      if (mon_nz > 1) check("one_slice_only", mon_nz, 1);
      if (cfg_bus != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", cfg_bus, 0);
        end else begin
          mon_e = sb.pop_front();
          check("sb_bus", cfg_bus, mon_e.bus);
          check("sb_done", pkt_done, mon_e.done);
        end
      end else if (pkt_done) begin
        check("done_without_beat", pkt_done, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_pe    = '0;
    s_last  = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;

    t1[0] = '{1'b1, 2'd0, 32'h0000_1234, 1'b0, {BUS_W{1'b0}},          1'b0};
    t1[1] = '{1'b1, 2'd0, 32'h0000_0000, 1'b0, slice_val(0, 32'h1234), 1'b0};
    t1[2] = '{1'b1, 2'd0, 32'd100,       1'b1, slice_val(0, 32'h0),    1'b0};
    t1[3] = '{1'b0, 2'd0, 32'h0,         1'b0, slice_val(0, 32'd100),  1'b1};
    t1[4] = '{1'b0, 2'd0, 32'h0,         1'b0, {BUS_W{1'b0}},          1'b0};
    t1[5] = '{1'b0, 2'd0, 32'h0,         1'b0, {BUS_W{1'b0}},          1'b0};

    exp2_bus[0] = slice_val(0, 32'hA000_0001); exp2_done[0] = 1'b0;
    exp2_bus[1] = slice_val(0, 32'hA000_0002); exp2_done[1] = 1'b0;
    exp2_bus[2] = slice_val(0, 32'hA000_0003); exp2_done[2] = 1'b1;
    exp2_bus[3] = '0;                          exp2_done[3] = 1'b0;
    exp2_bus[4] = slice_val(1, 32'h0000_5678); exp2_done[4] = 1'b1;
    exp2_bus[5] = '0;                          exp2_done[5] = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_cfg_bus", cfg_bus, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_underrun", underrun, 0);
    check("rst_bad_id", bad_id, 0);
    check("rst_s_ready", s_ready, 1);
    reset  = 1'b1;
    mon_en = 1'b1;
    tick();

    // 1: start, then a 3-word packet to PE0 streamed back-to-back
    pulse_start();
    check("t1_busy", busy, 1);
    for (int i = 0; i < 6; i++) begin
      s_valid = t1[i].v;
      s_pe    = t1[i].pe;
      s_data  = t1[i].d;
      s_last  = t1[i].l;
      if (t1[i].v) begin
        check($sformatf("t1_ready_%0d", i), s_ready, 1);
        sb_expect(int'(t1[i].pe), t1[i].d, t1[i].l);
      end
      tick();
      check($sformatf("t1_bus_%0d", i), cfg_bus, t1[i].exp_bus);
      check($sformatf("t1_done_%0d", i), pkt_done, t1[i].exp_done);
    end
    s_valid = 1'b0;
    check("t1_pkt_cnt", pkt_cnt, exp_cnt);

    // 2: two packets preloaded in IDLE, one gap cycle between them
    pulse_abort();
    check("t2_idle", busy, 0);
    push_word(0, 32'hA000_0001, 1'b0);
    push_word(0, 32'hA000_0002, 1'b0);
    push_word(0, 32'hA000_0003, 1'b1);
    push_word(1, 32'h0000_5678, 1'b1);
    check("t2_no_out_idle", cfg_bus, 0);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t2_bus_%0d", i), cfg_bus, exp2_bus[i]);
      check($sformatf("t2_done_%0d", i), pkt_done, exp2_done[i]);
    end
    drain(20);
    check("t2_pkt_cnt", pkt_cnt, exp_cnt);

    // 3: fill FIFO with no start; 17th word held off until a pop
    pulse_abort();
    for (int i = 0; i < 16; i++) push_word(1, 32'h300 + i, 1'b0);
    check("t3_full_ready", s_ready, 0);
    s_valid = 1'b1;
    s_pe    = 2'd1;
    s_data  = 32'h0000_03FF;
    s_last  = 1'b1;
    tick();
    tick();
    check("t3_held_ready", s_ready, 0);
    check("t3_held_idle", busy, 0);
    pulse_start();
    check("t3_ready_start_edge", s_ready, 0);
    tick();
    check("t3_ready_after_pop", s_ready, 1);
    sb_expect(1, 32'h0000_03FF, 1'b1);
    tick();
    s_valid = 1'b0;
    drain(100);
    check("t3_pkt_cnt", pkt_cnt, exp_cnt);

    // 4: source stalls mid-packet
    check("t4_underrun_clear", underrun, 0);
    push_word(0, 32'h0000_4444, 1'b0);
    tick();
    check("t4_word", cfg_bus, slice_val(0, 32'h0000_4444));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t4_stall_bus_%0d", i), cfg_bus, 0);
      check($sformatf("t4_underrun_%0d", i), underrun, 1);
    end
    push_word(0, 32'h0000_4445, 1'b1);
    drain(20);
    check("t4_underrun_sticky", underrun, 1);

    // 5: out-of-range PE index
    check("t5_bad_id_clear", bad_id, 0);
    push_word(3, 32'hBAD0_BAD0, 1'b0);
    push_word(1, 32'h0000_5555, 1'b1);
    drain(20);
    check("t5_bad_id", bad_id, 1);
    check("t5_pkt_cnt", pkt_cnt, exp_cnt);

    // 6: abort beats start with words buffered
    pulse_abort();
    for (int i = 0; i < 5; i++) push_word(0, 32'h600 + i, 1'b0);
    exp_cnt = int'(pkt_cnt);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    sb.delete();
    check("t6_idle", busy, 0);
    check("t6_ready", s_ready, 1);
    check("t6_bus", cfg_bus, 0);
    check("t6_underrun_kept", underrun, 1);
    check("t6_bad_id_kept", bad_id, 1);
    check("t6_pkt_cnt_kept", pkt_cnt, exp_cnt);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t6_flushed_%0d", i), cfg_bus, 0);
    end

    // 6b: asynchronous reset while a packet is on the bus
    push_word(2, 32'h0000_6666, 1'b0);
    tick();
    check("t6_mid_word", cfg_bus, slice_val(2, 32'h0000_6666));
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    sb.delete();
    check("t6_rst_bus", cfg_bus, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", pkt_done, 0);
    check("t6_rst_cnt", pkt_cnt, 0);
    check("t6_rst_underrun", underrun, 0);
    check("t6_rst_bad_id", bad_id, 0);
    check("t6_rst_ready", s_ready, 1);
    tick();
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
